// File: rtl/dw_prod_sum_div_pkg.sv
// Shared types and constant helpers for the sequential product-sum divider.
package dw_prod_sum_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_A_WIDTH   = 5;
   localparam int DEF_SUM_WIDTH = 11;

   function automatic int cnt_width(input int sum_width);
      return $clog2(sum_width + 1);
   endfunction

   // Divide-by-zero saturation values, truncated to the quotient width by the caller.
   function automatic logic [63:0] sat_max_pos(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min_neg(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/dw_prod_sum_div_step.sv
// One radix-2 non-restoring iteration: shift in a dividend bit, add or subtract the divisor.
module dw_prod_sum_div_step
   import dw_prod_sum_div_pkg::*;
#(
   parameter int A_width = DEF_A_WIDTH
) (
   input  logic [A_width:0]   p,
   input  logic [A_width-1:0] a_mag,
   input  logic               in_bit,
   output logic [A_width:0]   p_next,
   output logic               q_bit
);

   logic [A_width:0] p_shift;

   // Wrap-around in A_width+1 bits is harmless: the post-add/sub result always fits.
   always_comb begin
      p_shift = {p[A_width-1:0], in_bit};
      if (p[A_width])
         p_next = p_shift + {1'b0, a_mag};
      else
         p_next = p_shift - {1'b0, a_mag};
      q_bit = ~p_next[A_width];
   end

endmodule

// File: rtl/dw_prod_sum_div_seq.sv
// Sequential divider D = A*Q + R, one quotient bit per clock, start/done handshake.
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   CALC  | SUM_width non-restoring iterations, quotient MSB first
//   FIX   | remainder correction, sign application, divide-by-zero saturation
//   DONE  | results to output registers, done pulse
module dw_prod_sum_div_seq
   import dw_prod_sum_div_pkg::*;
#(
   parameter int A_width   = DEF_A_WIDTH,
   parameter int SUM_width = DEF_SUM_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 TC,
   input  logic [SUM_width-1:0] D,
   input  logic [A_width-1:0]   A,
   output logic                 busy,
   output logic                 done,
   output logic [SUM_width-1:0] Q,
   output logic [A_width-1:0]   R,
   output logic                 div_by_0
);

   localparam int CNT_W = cnt_width(SUM_width);
   localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(SUM_width - 1);
   localparam logic [SUM_width-1:0] SAT_POS  = SUM_width'(sat_max_pos(SUM_width));
   localparam logic [SUM_width-1:0] SAT_NEG  = SUM_width'(sat_min_neg(SUM_width));

   state_t state, state_nxt;

   logic [CNT_W-1:0]     cnt;
   logic [A_width:0]     p;
   logic [SUM_width-1:0] qd;
   logic [A_width-1:0]   a_mag;
   logic [A_width-1:0]   r_res;
   logic                 tc_q, q_neg, r_neg, dz;

   logic [A_width:0]     p_next;
   logic                 q_bit;
   logic [A_width-1:0]   a_abs, r_mag;
   logic [SUM_width-1:0] d_abs;

   dw_prod_sum_div_step #(.A_width(A_width)) u_step (
      .p      (p),
      .a_mag  (a_mag),
      .in_bit (qd[SUM_width-1]),
      .p_next (p_next),
      .q_bit  (q_bit)
   );

   always_comb begin
      a_abs = (TC && A[A_width-1]) ? -A : A;
      d_abs = (TC && D[SUM_width-1]) ? -D : D;
      r_mag = p[A_width-1:0] + (p[A_width] ? a_mag : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = CALC;
         CALC: if (cnt == LAST_CNT) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         p        <= '0;
         qd       <= '0;
         a_mag    <= '0;
         r_res    <= '0;
         tc_q     <= 1'b0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         dz       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Q        <= '0;
         R        <= '0;
         div_by_0 <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt   <= '0;
                  p     <= '0;
                  qd    <= d_abs;
                  a_mag <= a_abs;
                  tc_q  <= TC;
                  q_neg <= TC & (D[SUM_width-1] ^ A[A_width-1]);
                  r_neg <= TC & D[SUM_width-1];
                  dz    <= (A == '0);
               end
            end
            CALC: begin
               p   <= p_next;
               qd  <= {qd[SUM_width-2:0], q_bit};
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               if (dz) begin
                  r_res <= '0;
                  if (!tc_q)
                     qd <= '1;
                  else
                     qd <= r_neg ? SAT_NEG : SAT_POS;
               end else begin
                  qd    <= q_neg ? -qd : qd;
                  r_res <= r_neg ? -r_mag : r_mag;
               end
            end
            DONE: begin
               Q        <= qd;
               R        <= r_res;
               div_by_0 <= dz;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dw_prod_sum_div_seq.sv
// Scoreboard bench for dw_prod_sum_div_seq: driver pushes reference results, monitor checks on done.
module tb_dw_prod_sum_div_seq;

   localparam int AW  = 5;
   localparam int SW  = 11;
   localparam int LAT = SW + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          TC = 1'b0;
   logic [SW-1:0] D = '0;
   logic [AW-1:0] A = '0;
   logic          busy, done, div_by_0;
   logic [SW-1:0] Q;
   logic [AW-1:0] R;

   typedef struct {
      logic [SW-1:0] q;
      logic [AW-1:0] r;
      logic          dz;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   dw_prod_sum_div_seq #(.A_width(AW), .SUM_width(SW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .TC       (TC),
      .D        (D),
      .A        (A),
      .busy     (busy),
      .done     (done),
      .Q        (Q),
      .R        (R),
      .div_by_0 (div_by_0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: plain integer division, truncating toward zero in signed mode.
   function automatic exp_t model(input logic tc, input logic [SW-1:0] d, input logic [AW-1:0] a);
      exp_t e;
      int   ds, as_;
      e.cyc = 0;
      if (a == 0) begin
         e.dz = 1'b1;
         e.r  = '0;
         if (!tc)
            e.q = (1 << SW) - 1;
         else if (d[SW-1])
            e.q = SW'(-(1 << (SW - 1)));
         else
            e.q = SW'((1 << (SW - 1)) - 1);
      end else begin
         e.dz = 1'b0;
         if (!tc) begin
            e.q = SW'(int'(d) / int'(a));
            e.r = AW'(int'(d) % int'(a));
         end else begin
            ds  = d[SW-1] ? int'(d) - (1 << SW) : int'(d);
            as_ = a[AW-1] ? int'(a) - (1 << AW) : int'(a);
            e.q = SW'(ds / as_);
            e.r = AW'(ds % as_);
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: done pulse with no pending request (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("Q", 32'(Q), 32'(e.q));
            check("R", 32'(R), 32'(e.r));
            check("div_by_0", 32'(div_by_0), 32'(e.dz));
            check("latency", cyc, e.cyc);
            check("busy_low_at_done", 32'(busy), 0);
         end
      end
   end

   // Caller is positioned at a negedge when skip_sync=1 (back-to-back case).
   task automatic issue(input logic tc, input logic [SW-1:0] d, input logic [AW-1:0] a,
                        input bit expect_result, input bit skip_sync);
      exp_t e;
      int   guard;
      if (!skip_sync) @(negedge clk);
      guard = 0;
      while (busy && guard < 3 * LAT) begin
         @(negedge clk);
         guard++;
      end
      if (busy) check("idle_wait_timeout", 32'(busy), 0);
      TC    = tc;
      D     = d;
      A     = a;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (expect_result) begin
         e     = model(tc, d, a);
         e.cyc = cyc + LAT;
         sb.push_back(e);
      end
      check("busy_after_start", 32'(busy), 1);
      start = 1'b0;
      TC    = 1'($urandom);
      D     = SW'($urandom);
      A     = AW'($urandom);
   endtask

   task automatic wait_done();
      int guard = 0;
      @(negedge clk);
      while (!done && guard < 3 * LAT) begin
         @(negedge clk);
         guard++;
      end
      if (!done) check("done_timeout", 32'(done), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_Q"}, 32'(Q), 0);
      check({tag, "_R"}, 32'(R), 0);
      check({tag, "_div_by_0"}, 32'(div_by_0), 0);
   endtask

   initial begin
      int guard;
      logic [AW-1:0] ra;

      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(1'b0, 11'd1000, 5'd7,  1, 0);
      wait_done();
      issue(1'b1, 11'h79C,  5'd7,  1, 0);
      issue(1'b0, 11'd500,  5'd0,  1, 0);
      issue(1'b1, 11'h7FB,  5'd0,  1, 0);
      issue(1'b1, 11'h400,  5'h1F, 1, 0);
      issue(1'b1, 11'h3FF,  5'h10, 1, 0);
      issue(1'b0, 11'h7FF,  5'h1F, 1, 0);
      issue(1'b0, 11'd3,    5'd9,  1, 0);

      // Starts while busy must be ignored.
      issue(1'b0, 11'd777, 5'd13, 1, 0);
      repeat (3) @(negedge clk);
      TC = 1'b1; D = 11'h123; A = 5'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(negedge clk);
      D = 11'h456; A = 5'd0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;

      // Back-to-back: start held during the done cycle.
      wait_done();
      issue(1'b1, 11'h6A5, 5'h0B, 1, 1);
      wait_done();

      // Reset mid-operation aborts with no done.
      issue(1'b0, 11'd999, 5'd4, 0, 0);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(1'b1, 11'h0C8, 5'h1D, 1, 0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0:       ra = '0;
            1:       ra = '1;
            2:       ra = 5'h10;
            default: ra = AW'($urandom);
         endcase
         issue(1'($urandom), SW'($urandom), ra, 1, ($urandom_range(0, 3) == 0) && done);
      end

      guard = 0;
      while (sb.size() != 0 && guard < 4 * LAT) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      check("pending_results", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dw_prod_sum_div_seq.md
# dw_prod_sum_div_seq

Sequential inverse of the product-sum datapath: given a SUM_width-bit dividend D and an A_width-bit divisor A, iteratively computes quotient Q and remainder R with D = A*Q + R, unsigned or two's complement per TC. One radix-2 non-restoring iteration per clock, with a start/done handshake. It sits downstream of product-sum units to recover the multiplicand and residual from an accumulated SUM.

## Interface
- A_width, 5, divisor width; also the remainder width (min 2).
- SUM_width, 11, dividend and quotient width (must be ≥ A_width).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- TC  input  1  0 = unsigned, 1 = two's complement; latched with start.
- D  input  SUM_width  dividend; latched with start.
- A  input  A_width  divisor; latched with start.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse; Q/R/div_by_0 valid from this cycle on.
- Q  output  SUM_width  quotient.
- R  output  A_width  remainder.
- div_by_0  output  1  divisor was zero.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: on start=1, latch D, A and TC; store magnitudes when TC=1; record result signs (Q negative iff signs differ, R takes the dividend's sign); clear the iteration counter; go to CALC.
- CALC: one quotient bit per cycle, MSB first, for exactly SUM_width cycles. Partial remainder is A_width+1 bits. Then go to FIX.
- FIX: final remainder correction (add the divisor back if negative). Apply signs: Q and R are negated as recorded. Go to DONE.
- DONE: register Q, R and div_by_0, pulse done, return to IDLE.
- Signed rounding truncates toward zero, so |R| < |A| and R has D's sign (or is 0).
- Divide by zero (A=0):
  - unsigned: Q = all ones, R = 0.
  - signed: Q = 2^(SUM_width-1)-1 if D ≥ 0, else -2^(SUM_width-1); R = 0.
  - div_by_0 = 1 in both modes; the full cycle count still elapses.
- Signed overflow (D = -2^(SUM_width-1), A = -1): Q wraps to -2^(SUM_width-1), R = 0, div_by_0 = 0.
- start while busy=1 (CALC/FIX/DONE) is ignored; no queuing.
- Inputs D, A and TC may change freely after the start cycle.
- Q, R and div_by_0 hold their last result until the next DONE.

## Timing
- Reset (rst_n low, asynchronous): FSM → IDLE; busy = 0, done = 0, Q = 0, R = 0, div_by_0 = 0; counter and datapath registers cleared.
- rst_n deassertion is sampled synchronously; the first start is accepted on the first rising edge with rst_n = 1.
- start sampled at edge k:
  - busy = 1 from k to k+SUM_width+2.
  - done = 1 exactly for the cycle after edge k+SUM_width+2 (latency SUM_width+2 clocks; 13 with defaults).
  - busy falls in the same cycle that done rises.
- Back-to-back: start asserted during the done cycle is accepted at that edge (FSM is back in IDLE). Maximum throughput is one result per SUM_width+2 clocks.
- Reset mid-operation aborts the computation; no done pulse; outputs are returned to their reset values.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package dw_prod_sum_div_pkg:
  - FSM state enum (IDLE, CALC, FIX, DONE).
  - counter width constant, clog2(SUM_width+1).
  - divide-by-zero saturation constant functions.
- One natural sub-module, dw_prod_sum_div_step: the combinational single-iteration add/subtract plus quotient-bit select, instantiated once in the top.
- The top owns the FSM, counter, sign pre/post-processing and output registers.

## Test plan
All scenarios use default parameters (A_width=5, SUM_width=11).
- Unsigned: TC=0, D=1000, A=7 → done 13 clocks after start; Q=142, R=6, div_by_0=0.
- Signed: TC=1, D=-100 (11'h79C), A=7 → Q=-14 (11'h7F2), R=-2 (5'h1E).
- Divide by zero: TC=0, D=500, A=0 → Q=11'h7FF, R=0, div_by_0=1. With TC=1, D=-5, A=0 → Q=11'h400, R=0, div_by_0=1.
- Signed overflow: TC=1, D=11'h400, A=5'h1F (-1) → Q=11'h400, R=0, div_by_0=0.
- Handshake:
  - start re-pulsed at cycles 3 and 8 of an operation → ignored; exactly one done.
  - start held during the done cycle → second result 13 clocks later.
- Reset mid-operation: rst_n pulled low at cycle 6 → busy, done, Q and R go to 0 immediately (asynchronously); no done pulse.
  - A new start after release → correct result with full latency.
